// File: rtl/shared_pkg.sv
// Shared FIFO constants plus the read-controller state type.
package shared_pkg;

   localparam int FIFO_WIDTH     = 16;
   localparam int FIFO_DEPTH     = 8;
   localparam int SKID_DEPTH_DEF = 3;

   typedef enum logic [1:0] {RD_IDLE, RD_ACTIVE, RD_STOP} rd_state_e;

endpackage

// File: rtl/fifo_rd_ctrl_sva.sv
// Protocol checks for fifo_rd_ctrl, attached to every instance through bind.
module fifo_rd_ctrl_sva #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 3
) (
   input logic             clk,
   input logic             rst_n,
   input logic             empty,
   input logic             rd_en,
   input logic             push,
   input logic [2:0]       occupancy,
   input logic             m_valid,
   input logic             m_ready,
   input logic [WIDTH-1:0] m_data
);

   localparam logic [2:0] FULL_OCC = 3'(DEPTH);

   a_no_rd_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
      !(rd_en && empty));

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && occupancy == FULL_OCC));

   a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

bind fifo_rd_ctrl fifo_rd_ctrl_sva #(
   .WIDTH (FIFO_WIDTH),
   .DEPTH (SKID_DEPTH)
) u_sva (
   .clk       (clk),
   .rst_n     (rst_n),
   .empty     (empty),
   .rd_en     (rd_en),
   .push      (push),
   .occupancy (occupancy),
   .m_valid   (m_valid),
   .m_ready   (m_ready),
   .m_data    (m_data)
);

// File: rtl/skid_buf.sv
// Circular buffer holding FIFO words that are in flight to the stream consumer.
// The head entry is presented directly as stream data.
module skid_buf #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [2:0]       occupancy,
   output logic [WIDTH-1:0] head_data
);

   localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [2:0]       FULL_OCC = 3'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0]       occ_q, occ_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 3'd1;
         2'b01:   occ_d = occ_q - 3'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign occupancy = occ_q;
   assign head_data = mem_q[rd_ptr_q];

   // Read credits upstream must keep the buffer from ever overflowing or being over-popped.
   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && occ_q == FULL_OCC));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop && occ_q == 3'd0));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: issues credit-limited reads, absorbs the 1-cycle
// read latency in a skid buffer and presents the words as a valid/ready stream.
module fifo_rd_ctrl #(
   parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
   parameter int SKID_DEPTH = shared_pkg::SKID_DEPTH_DEF,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  empty,
   input  logic                  underflow,
   input  logic [FIFO_WIDTH-1:0] data_out,
   output logic                  rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  busy,
   output logic [CNT_W-1:0]      word_cnt,
   output logic                  err_underflow
);

   import shared_pkg::*;

   localparam logic [2:0] SKID_DEPTH_C = 3'(SKID_DEPTH);

   rd_state_e        state_q, state_d;
   logic             inflight_q, inflight_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic             err_q, err_d;
   logic [2:0]       occupancy;
   logic [2:0]       credit_used;
   logic             push, pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RD_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RD_IDLE:   if (enable) state_d = RD_ACTIVE;
         RD_ACTIVE: if (!enable) state_d = RD_STOP;
         RD_STOP: begin
            if (enable)
               state_d = RD_ACTIVE;
            else if (!inflight_q && occupancy == 3'd0)
               state_d = RD_IDLE;
         end
         default:   state_d = RD_IDLE;
      endcase
   end

   // A read is only issued when a buffer slot is guaranteed for its data,
   // counting the word already on its way back from the FIFO.
   always_comb begin
      credit_used = occupancy + {2'b00, inflight_q};
      rd_en       = (state_q == RD_ACTIVE) && !empty && (credit_used < SKID_DEPTH_C);
      busy        = (state_q != RD_IDLE);
      m_valid     = (occupancy != 3'd0);
      push        = inflight_q && !underflow;
      pop         = m_valid && m_ready;
      inflight_d  = rd_en;
      word_cnt_d  = pop ? word_cnt_q + CNT_W'(1) : word_cnt_q;
      err_d       = err_q || (inflight_q && underflow);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         word_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         word_cnt_q <= word_cnt_d;
         err_q      <= err_d;
      end
   end

   skid_buf #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (data_out),
      .pop       (pop),
      .occupancy (occupancy),
      .head_data (m_data)
   );

   assign word_cnt      = word_cnt_q;
   assign err_underflow = err_q;

endmodule
